// File: rtl/mux_arb_n.sv
// N-channel registered multiplexer with valid/ready handshake on every channel.
// Selection is either fixed (external sel) or round-robin.
module mux_arb_n #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      grant
);

  // The pointer wraps at NCH, not at 2**SELW, so unused encodings never appear.
  function automatic logic [SELW-1:0] wrap_next(input logic [SELW-1:0] idx);
    if (int'(idx) + 1 >= NCH) return '0;
    else                      return idx + 1'b1;
  endfunction

  logic [WIDTH-1:0] data_p0;
  logic [SELW-1:0]  grant_p0;
  logic             vld_p0;
  logic [SELW-1:0]  ptr;

  logic             ld;
  logic             req;
  logic [SELW-1:0]  chosen;
  logic [WIDTH-1:0] chosen_data;
  logic             xfer;
  int               idx;

  assign ld = !vld_p0 | out_ready;

  always_comb begin
    req    = 1'b0;
    chosen = '0;
    idx    = 0;
    if (!mode) begin
      chosen = sel;
      for (int i = 0; i < NCH; i++)
        if (SELW'(i) == sel && in_valid[i]) req = 1'b1;
    end else begin
      // Scan upward from ptr; ptr is always < NCH, so one subtraction wraps.
      for (int k = 0; k < NCH; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NCH) idx = idx - NCH;
        if (!req && in_valid[idx]) begin
          req    = 1'b1;
          chosen = SELW'(idx);
        end
      end
    end
  end

  always_comb begin
    chosen_data = '0;
    for (int i = 0; i < NCH; i++)
      if (SELW'(i) == chosen) chosen_data = in_data[i*WIDTH +: WIDTH];
  end

  assign xfer = ld & req & !reset;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NCH; i++)
      if (xfer && SELW'(i) == chosen) in_ready[i] = 1'b1;
  end

  // Stage p0: single output register with back-pressure
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p0  <= '0;
      grant_p0 <= '0;
      vld_p0   <= 1'b0;
      ptr      <= '0;
    end else if (ld) begin
      if (req) begin
        data_p0  <= chosen_data;
        grant_p0 <= chosen;
        vld_p0   <= 1'b1;
        if (mode) ptr <= wrap_next(chosen);
      end else begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign out_data  = data_p0;
  assign out_valid = vld_p0;
  assign grant     = grant_p0;

endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
Parametrised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshake. It succeeds the 4-bit 2:1 combinational mux used in the ALU datapath. It supports two modes:
- fixed mode: external select picks the channel;
- round-robin mode: internal fair arbitration picks the channel.

The result goes into a single output register stage with back-pressure. It sits between multiple operand/result producers and one ALU consumer.

Parameters:
WIDTH, 4, data bits per channel
NCH, 4, number of input channels (2..16)
SELW, 2, select/grant width; must satisfy 2**SELW >= NCH

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  NCH  channel i offers data
in_ready  output  NCH  channel i data accepted this cycle (combinational)
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SELW  channel index used in fixed mode
out_data  output  WIDTH  registered selected data
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts out_data this cycle
grant  output  SELW  index of the channel out_data came from (registered)

Behaviour:
- Reset, sampled on a clk edge with reset=1:
  - out_data=0, out_valid=0, grant=0, round-robin pointer ptr=0.
  - Any held word is discarded, including when reset arrives mid-stream.
  - in_ready is 0 in any cycle where reset=1.
- Load enable: ld = !out_valid | out_ready.
- Channel choice (combinational, each cycle):
  - Fixed mode (mode=0): chosen=sel. A request exists iff sel<NCH and in_valid[sel]=1. sel>=NCH means no request.
  - Round-robin mode (mode=1): scan indices ptr, ptr+1, …, NCH-1, 0, …, ptr-1. chosen = first index with in_valid=1. No request if in_valid==0.
- Ready rule: in_ready[i] = ld & request & (i==chosen) & !reset.
  - At most one bit of in_ready is set per cycle.
  - in_ready never depends on in_valid of other channels in fixed mode.
- Input transfer on channel i: in_valid[i] & in_ready[i]. On that clk edge:
  - out_data <= in_data slice of chosen;
  - grant <= chosen;
  - out_valid <= 1;
  - if mode=1: ptr <= (chosen+1) mod NCH, with wrap at NCH, not at 2**SELW.
- ld=1 with no request: out_valid <= 0; out_data and grant hold their previous values.
- ld=0 (out_valid=1, out_ready=0):
  - out_data, grant and out_valid hold;
  - ptr holds;
  - all in_ready=0.
- Latency: 1 cycle, input transfer to out_valid.
- Throughput: 1 word/cycle while out_ready=1. Simultaneous consume and load in the same cycle is allowed and loses no bubble.
- Fixed mode leaves ptr unchanged.
- Mode or sel change takes effect on the same cycle's choice. There is no pipeline of select.
- Data is passed unmodified, with no width conversion. Unused grant encodings never appear on the grant output.

Test Plan:
- Reset then idle: assert reset 2 cycles, all in_valid=0 -> out_valid=0, out_data=0, grant=0, in_ready=0000; same values after reset released.
- Fixed mode transfer (NCH=4, WIDTH=4): mode=0, sel=2, in_valid=0100, channel 2 data=4'hA, out_ready=1 -> in_ready=0100 that cycle; next cycle out_valid=1, out_data=A, grant=2. Then sel=3 with in_valid[3]=0 -> out_valid=0 following cycle.
- Back-pressure: out_valid=1, out_data=5, out_ready=0 for 3 cycles with channel 1 valid (data=7) -> in_ready=0000, out_data stays 5; raise out_ready -> same cycle in_ready=0010, next cycle out_data=7.
- Round-robin fairness: mode=1, in_valid=1111 constant, data channel i = i+8, out_ready=1 from reset -> grant sequence 0,1,2,3,0,1 and out_data 8,9,A,B,8,9.
- Round-robin skip and wrap: ptr=3 after granting channel 2, in_valid=0011 -> grant=0, then ptr=1 -> grant=1, then ptr=2 with in_valid=0001 -> grant=0.
- Reset mid-stream: out_valid=1, out_ready=0, ptr=2; assert reset one cycle -> out_valid=0, out_data=0, grant=0. With in_valid=1111 in round-robin, the next grant is 0.
